fifo_word_packer: RTL and testbench

- Parametrised successor to the convolution-core output FIFO controller.
- Drains WORD_W-bit result words from the synchronous output FIFO and packs LANES words per beat onto a wide output bus with a valid/ready handshake.
- Total word count per job is size*size, latched at job start. A short final beat is zero-padded and flagged with a lane mask and last.
- Sits between the convolution output FIFO and the wide system/DMA write port.

---
 rtl/fifo_word_packer_pkg.sv | 25 ++
 rtl/fifo_word_packer_if.sv | 29 ++
 rtl/fifo_word_packer_lane_reg.sv | 39 +++
 rtl/fifo_word_packer.sv | 136 +++++++++++++
 tb/tb_fifo_word_packer.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_word_packer_pkg.sv
// conv_core_pkg: shared types and helpers for the convolution-core output path.
// Holds the packer state codes, default widths and the lane-mask helper.
package conv_core_pkg;

   localparam int WORD_W_DEF = 32;
   localparam int LANES_DEF  = 4;

   typedef logic [1:0] pk_state_t;

   localparam pk_state_t ST_IDLE = 2'd0;
   localparam pk_state_t ST_FILL = 2'd1;
   localparam pk_state_t ST_SEND = 2'd2;
   localparam pk_state_t ST_DONE = 2'd3;

   // Low n bits set; saturates at 32 lanes.
   function automatic logic [31:0] lane_mask(input int unsigned n);
      logic [31:0] m;
      m = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         m[i] = (i < n);
      end
      return m;
   endfunction

endpackage

// File: rtl/fifo_word_packer_if.sv
// fifo_word_packer_if: FIFO read side and wide output beat handshake.
// master = packer, slave = FIFO plus downstream write port.
interface fifo_word_packer_if
   import conv_core_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF,
   parameter int LANES  = LANES_DEF
) ();

   logic                    fifo_empty;
   logic [WORD_W-1:0]       fifo_data;
   logic                    fifo_rd_en;
   logic [WORD_W*LANES-1:0] out_data;
   logic                    out_valid;
   logic                    out_ready;
   logic                    out_last;
   logic [LANES-1:0]        out_lane_mask;

   modport master (
      input  fifo_empty, fifo_data, out_ready,
      output fifo_rd_en, out_data, out_valid, out_last, out_lane_mask
   );

   modport slave (
      output fifo_empty, fifo_data, out_ready,
      input  fifo_rd_en, out_data, out_valid, out_last, out_lane_mask
   );

endinterface

// File: rtl/fifo_word_packer_lane_reg.sv
// packer_lane_reg: LANES x WORD_W lane store with indexed write and clear.
// Lanes outside the show mask read back as zero.
module packer_lane_reg #(
   parameter int WORD_W = 32,
   parameter int LANES  = 4,
   parameter int IW     = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    wr_en,
   input  logic [IW-1:0]           wr_idx,
   input  logic [WORD_W-1:0]       wr_data,
   input  logic [LANES-1:0]        show,
   output logic [WORD_W*LANES-1:0] data
);

   logic [WORD_W-1:0] lane_q [LANES];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < LANES; i++) lane_q[i] <= '0;
      end else if (clr) begin
         for (int i = 0; i < LANES; i++) lane_q[i] <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < LANES; i++) begin
            if (wr_idx == IW'(i)) lane_q[i] <= wr_data;
         end
      end
   end

   always_comb begin
      data = '0;
      for (int i = 0; i < LANES; i++) begin
         data[i*WORD_W +: WORD_W] = show[i] ? lane_q[i] : '0;
      end
   end

endmodule

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: drains size*size FIFO words into LANES-wide output beats.
// Define FIFO_WORD_PACKER_BEAT_CNT_EN to add the beat_cnt output.
module fifo_word_packer
   import conv_core_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF,
   parameter int LANES  = LANES_DEF,
   parameter int SIZE_W = 8,
   parameter int CNT_W  = 2*SIZE_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [SIZE_W-1:0] size,
   input  logic              size_valid,
   fifo_word_packer_if.master bus,
   output logic              busy,
   output logic              done
`ifdef FIFO_WORD_PACKER_BEAT_CNT_EN
   ,
   output logic [CNT_W-1:0]  beat_cnt
`endif
);

   localparam int IW = $clog2(LANES+1);

   pk_state_t        state;
   logic [CNT_W-1:0] remaining;
   logic [CNT_W-1:0] req_left;
   logic [CNT_W-1:0] prod;
   logic [IW-1:0]    lane_wr;
   logic [IW-1:0]    lane_req;
   logic [IW-1:0]    nxt_wr;
   logic             rd_pend;
   logic             start;
   logic             rd_en;
   logic             beat_end;
   logic             accept;

   assign prod   = CNT_W'(size) * CNT_W'(size);
   assign start  = size_valid && (state == ST_IDLE || state == ST_DONE);
   assign rd_en  = (state == ST_FILL) && !bus.fifo_empty &&
                   (req_left != '0) && (lane_req < IW'(LANES));
   assign nxt_wr = lane_wr + IW'(1);
   // rd_pend only ever lands inside FILL: no read is left open at SEND.
   assign beat_end = rd_pend &&
                     (nxt_wr == IW'(LANES) || remaining == CNT_W'(1));
   assign accept = (state == ST_SEND) && bus.out_valid && bus.out_ready;
   assign busy   = (state == ST_FILL) || (state == ST_SEND);

   assign bus.fifo_rd_en = rd_en;

   packer_lane_reg #(
      .WORD_W (WORD_W),
      .LANES  (LANES),
      .IW     (IW)
   ) u_lanes (
      .clk     (clk),
      .rst     (rst),
      .clr     (accept),
      .wr_en   (rd_pend),
      .wr_idx  (lane_wr),
      .wr_data (bus.fifo_data),
      .show    (bus.out_lane_mask),
      .data    (bus.out_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state             <= ST_IDLE;
         remaining         <= '0;
         req_left          <= '0;
         lane_wr           <= '0;
         lane_req          <= '0;
         rd_pend           <= 1'b0;
         done              <= 1'b0;
         bus.out_valid     <= 1'b0;
         bus.out_last      <= 1'b0;
         bus.out_lane_mask <= '0;
      end else begin
         rd_pend <= rd_en;
         unique case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  remaining <= prod;
                  req_left  <= prod;
                  lane_wr   <= '0;
                  lane_req  <= '0;
                  done      <= (prod == '0);
                  state     <= (prod == '0) ? ST_DONE : ST_FILL;
               end
            end
            ST_FILL: begin
               if (rd_en) begin
                  req_left <= req_left - CNT_W'(1);
                  lane_req <= lane_req + IW'(1);
               end
               if (rd_pend) begin
                  lane_wr   <= nxt_wr;
                  remaining <= remaining - CNT_W'(1);
               end
               if (beat_end) begin
                  state             <= ST_SEND;
                  bus.out_valid     <= 1'b1;
                  bus.out_lane_mask <= LANES'(lane_mask(32'(nxt_wr)));
                  bus.out_last      <= (remaining == CNT_W'(1));
               end
            end
            ST_SEND: begin
               if (accept) begin
                  lane_wr           <= '0;
                  lane_req          <= '0;
                  bus.out_valid     <= 1'b0;
                  bus.out_last      <= 1'b0;
                  bus.out_lane_mask <= '0;
                  done              <= bus.out_last;
                  state             <= bus.out_last ? ST_DONE : ST_FILL;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef FIFO_WORD_PACKER_BEAT_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat_cnt <= '0;
      end else if (start) begin
         beat_cnt <= '0;
      end else if (accept) begin
         beat_cnt <= beat_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: random and directed jobs against a queue model.
// The model slices the job's word list into LANES-wide beats directly.
`timescale 1ns/1ps
module tb_fifo_word_packer;
   import conv_core_pkg::*;

   localparam int WORD_W = 32;
   localparam int LANES  = 4;
   localparam int SIZE_W = 8;
   localparam int CNT_W  = 16;
   localparam int BW     = WORD_W*LANES;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [SIZE_W-1:0] size = '0;
   logic              size_valid = 1'b0;
   logic              busy;
   logic              done;
`ifdef FIFO_WORD_PACKER_BEAT_CNT_EN
   logic [CNT_W-1:0]  beat_cnt;
`endif

   fifo_word_packer_if #(.WORD_W(WORD_W), .LANES(LANES)) bus ();

   fifo_word_packer #(
      .WORD_W (WORD_W),
      .LANES  (LANES),
      .SIZE_W (SIZE_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .size       (size),
      .size_valid (size_valid),
      .bus        (bus.master),
      .busy       (busy),
      .done       (done)
`ifdef FIFO_WORD_PACKER_BEAT_CNT_EN
      ,
      .beat_cnt   (beat_cnt)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [BW-1:0] got,
                        input logic [BW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [WORD_W-1:0] fq [$];
   logic [BW-1:0]     exp_data [$];
   logic [LANES-1:0]  exp_mask [$];
   logic              exp_last [$];
   int nreads = 0;
   int beats = 0;
   int hold = 0;
   int stall_mode = 0;
   int ready_mode = 0;

   // FIFO model: data appears one cycle after the read request.
   initial begin
      bus.fifo_data = '0;
      forever begin
         @(posedge clk);
         if (rst && bus.fifo_rd_en) begin
            nreads++;
            if (fq.size() > 0) bus.fifo_data <= fq.pop_front();
            else bus.fifo_data <= '0;
         end
      end
   end

   // Negedge monitor: checks the held beat, drives empty/ready, scores beats.
   initial begin
      logic          pend;
      logic [BW-1:0] pd;
      logic [LANES-1:0] pm;
      logic          pl;
      logic          stall;
      int            toggle;
      pend = 1'b0; pd = '0; pm = '0; pl = 1'b0; toggle = 0;
      bus.fifo_empty = 1'b1;
      bus.out_ready  = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            pend = 1'b0;
         end else begin
            if (pend) begin
               check("hold_valid", BW'(bus.out_valid), BW'(1));
               check("hold_data", bus.out_data, pd);
               check("hold_mask", BW'(bus.out_lane_mask), BW'(pm));
               check("hold_last", BW'(bus.out_last), BW'(pl));
            end
            if (bus.out_valid) begin
               check("rd_in_send", BW'(bus.fifo_rd_en), BW'(0));
            end
            toggle = 1 - toggle;
            if (stall_mode == 1) stall = 1'($urandom_range(0, 1));
            else if (stall_mode == 2) stall = (toggle == 1);
            else stall = 1'b0;
            bus.fifo_empty = (fq.size() == 0) || stall;
            if (ready_mode == 1) begin
               bus.out_ready = 1'($urandom_range(0, 1));
            end else if (ready_mode == 2 && beats == 1 &&
                         bus.out_valid && hold < 5) begin
               bus.out_ready = 1'b0;
               hold++;
            end else begin
               bus.out_ready = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
               if (exp_data.size() == 0) begin
                  check("extra_beat", BW'(1), BW'(0));
               end else begin
                  check("beat_data", bus.out_data, exp_data.pop_front());
                  check("beat_mask", BW'(bus.out_lane_mask),
                        BW'(exp_mask.pop_front()));
                  check("beat_last", BW'(bus.out_last),
                        BW'(exp_last.pop_front()));
               end
               beats++;
               pend = 1'b0;
            end else if (bus.out_valid) begin
               pend = 1'b1;
               pd = bus.out_data;
               pm = bus.out_lane_mask;
               pl = bus.out_last;
            end
         end
      end
   end

   task automatic load_job(input int n, input bit seq);
      logic [WORD_W-1:0] w [$];
      logic [BW-1:0]     d;
      int nb;
      int cnt;
      fq.delete();
      exp_data.delete();
      exp_mask.delete();
      exp_last.delete();
      for (int i = 0; i < n; i++) begin
         w.push_back(seq ? WORD_W'(i) : WORD_W'($urandom()));
         fq.push_back(w[i]);
      end
      nb = (n + LANES - 1) / LANES;
      for (int b = 0; b < nb; b++) begin
         d = '0;
         cnt = 0;
         for (int l = 0; l < LANES; l++) begin
            if (b*LANES + l < n) begin
               d[l*WORD_W +: WORD_W] = w[b*LANES + l];
               cnt++;
            end
         end
         exp_data.push_back(d);
         exp_mask.push_back(LANES'((1 << cnt) - 1));
         exp_last.push_back(b == nb - 1);
      end
   endtask

   task automatic run_job(input int sz, input int smode, input int rmode,
                          input bit seq, input bit poke);
      int n;
      int nb;
      n  = sz * sz;
      nb = (n + LANES - 1) / LANES;
      load_job(n, seq);
      stall_mode = smode;
      ready_mode = rmode;
      nreads = 0;
      beats  = 0;
      hold   = 0;
      @(negedge clk);
      size = SIZE_W'(sz);
      size_valid = 1'b1;
      @(negedge clk);
      size_valid = 1'b0;
      if (n == 0) begin
         check("zero_done", BW'(done), BW'(1));
         check("zero_busy", BW'(busy), BW'(0));
         check("zero_valid", BW'(bus.out_valid), BW'(0));
      end else begin
         check("start_busy", BW'(busy), BW'(1));
         check("start_done", BW'(done), BW'(0));
         if (poke) begin
            repeat (2) @(negedge clk);
            size = SIZE_W'(7);
            size_valid = 1'b1;
            @(negedge clk);
            size_valid = 1'b0;
         end
         for (int c = 0; c < 3000 && !done; c++) @(negedge clk);
      end
      check("done", BW'(done), BW'(1));
      check("busy_end", BW'(busy), BW'(0));
      repeat (3) @(negedge clk);
      check("reads", BW'(nreads), BW'(n));
      check("beats", BW'(beats), BW'(nb));
      check("exp_left", BW'(exp_data.size()), BW'(0));
      check("done_held", BW'(done), BW'(1));
      if (rmode == 2) check("ready_hold", BW'(hold), BW'(5));
`ifdef FIFO_WORD_PACKER_BEAT_CNT_EN
      check("beat_cnt", BW'(beat_cnt), BW'(nb));
`endif
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, BW'(bus.out_valid), BW'(0));
      check({tag, "_last"}, BW'(bus.out_last), BW'(0));
      check({tag, "_mask"}, BW'(bus.out_lane_mask), BW'(0));
      check({tag, "_data"}, bus.out_data, BW'(0));
      check({tag, "_rd"}, BW'(bus.fifo_rd_en), BW'(0));
      check({tag, "_busy"}, BW'(busy), BW'(0));
      check({tag, "_done"}, BW'(done), BW'(0));
`ifdef FIFO_WORD_PACKER_BEAT_CNT_EN
      check({tag, "_bcnt"}, BW'(beat_cnt), BW'(0));
`endif
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_reset_outputs("rst0");
      rst = 1'b1;
      @(negedge clk);

      run_job(4, 0, 0, 1'b1, 1'b0);
      run_job(3, 0, 0, 1'b1, 1'b0);
      run_job(4, 0, 2, 1'b1, 1'b0);
      run_job(2, 2, 0, 1'b1, 1'b0);
      run_job(0, 0, 0, 1'b1, 1'b0);
      run_job(3, 1, 1, 1'b0, 1'b1);

      // Abort mid-FILL with a read in flight.
      load_job(9, 1'b0);
      stall_mode = 0;
      ready_mode = 0;
      @(negedge clk);
      size = SIZE_W'(3);
      size_valid = 1'b1;
      @(negedge clk);
      size_valid = 1'b0;
      #1;
      check("rd_before_rst", BW'(bus.fifo_rd_en), BW'(1));
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      fq.delete();
      exp_data.delete();
      exp_mask.delete();
      exp_last.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      run_job(2, 0, 0, 1'b1, 1'b0);

      for (int j = 0; j < 8; j++) begin
         run_job(int'($urandom_range(1, 7)), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 1)), 1'b0, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
